// File: rtl/register_file_if.sv
// register_file_if: write-side controls and read-port operands between the register file and its driver.
interface register_file_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] I;
    logic [2:0]       FunSel;
    logic [3:0]       RegSel;
    logic [3:0]       ScrSel;
    logic [2:0]       OutASel;
    logic [2:0]       OutBSel;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;

    modport master (
        output I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
        input  OutA, OutB
    );

    modport slave (
        input  I, FunSel, RegSel, ScrSel, OutASel, OutBSel,
        output OutA, OutB
    );
endinterface

// File: rtl/register_file.sv
// register_file: general registers R1-R4 and optional scratch S1-S4 driving the ALU operand ports.
// Scratch bank is built only when REGFILE_SCRATCH_EN is defined; otherwise select codes 1xx read 0.
module register_file #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    register_file_if.slave bus
);
    logic [WIDTH-1:0] r [4];

    // Each register derives its result from its own current value, so multi-register ops stay independent.
    function automatic logic [WIDTH-1:0] next_val(
        input logic [2:0]       f,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        case (f)
            3'b000:  return q - WIDTH'(1);
            3'b001:  return q + WIDTH'(1);
            3'b010:  return d;
            3'b011:  return '0;
            3'b100:  return WIDTH'(d[7:0]);
            3'b101:  return WIDTH'(d[15:0]);
            3'b110:  return {q[WIDTH-9:0], d[7:0]};
            default: return WIDTH'($signed(d[15:0]));
        endcase
    endfunction

    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++)
            if (reset) r[k] <= '0;
            else if (bus.RegSel[3-k]) r[k] <= next_val(bus.FunSel, r[k], bus.I);
    end

`ifdef REGFILE_SCRATCH_EN
    logic [WIDTH-1:0] s [4];

    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++)
            if (reset) s[k] <= '0;
            else if (bus.ScrSel[3-k]) s[k] <= next_val(bus.FunSel, s[k], bus.I);
    end

    always_comb begin
        bus.OutA = bus.OutASel[2] ? s[bus.OutASel[1:0]] : r[bus.OutASel[1:0]];
        bus.OutB = bus.OutBSel[2] ? s[bus.OutBSel[1:0]] : r[bus.OutBSel[1:0]];
    end
`else
    logic unused_scr;

    assign unused_scr = ^bus.ScrSel;

    always_comb begin
        bus.OutA = bus.OutASel[2] ? '0 : r[bus.OutASel[1:0]];
        bus.OutB = bus.OutBSel[2] ? '0 : r[bus.OutBSel[1:0]];
    end
`endif
endmodule
